// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the pattern scan controller and its matcher.
package pattern_scan_pkg;

  localparam int PAT_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A usable pattern has between 1 and pat_max bits.
  function automatic logic len_legal(input logic [2:0] len, input int pat_max);
    return (len != 3'd0) && (int'(len) <= pat_max);
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word input handshake between the front end (master) and the scan controller (slave).
interface pattern_scan_ctrl_if #(
  parameter int WORD_W = 8
) ();
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl_matcher.sv
// Overlapping Mealy matcher: keeps the recent bit history and flags a hit on the current bit.
module pattern_matcher
  import pattern_scan_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clr,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [2:0]         len,
  output logic               match
);

  localparam int SEEN_W = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-2:0] hist_reg;
  logic [SEEN_W-1:0]  seen_reg;
  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] mask;
  logic               hit;

  assign window = {hist_reg, bit_in};

  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
    assign mask[gi] = (gi < int'(len));
  end

  assign hit   = (((window ^ pattern) & mask) == '0);
  assign match = bit_valid && hit && (int'(seen_reg) >= int'(len) - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
      seen_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      seen_reg <= '0;
    end else if (bit_valid) begin
      hist_reg <= window[PAT_MAX-2:0];
      if (seen_reg != SEEN_W'(PAT_MAX)) seen_reg <= seen_reg + SEEN_W'(1);
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer: accepts words, serializes them MSB-first into the matcher, counts hits.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [2:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  pattern_scan_ctrl_if.slave in_bus,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int KW = $clog2(WORD_W);

  state_t             state_reg, state_next;
  logic [WORD_W-1:0]  shift_reg;
  logic [KW-1:0]      k_reg;
  logic [PAT_MAX-1:0] pat_reg;
  logic [2:0]         len_reg;
  logic [CNT_W-1:0]   thresh_reg;
  logic               ready_reg;
  logic [CNT_W:0]     cnt_plus;
  logic               legal;
  logic               accept;
  logic               hit_thresh;

  assign legal      = len_legal(cfg_len, PAT_MAX);
  assign accept     = (state_reg == IDLE) && start && !abort && legal;
  assign cnt_plus   = {1'b0, match_cnt} + (CNT_W + 1)'(1);
  assign hit_thresh = match && (thresh_reg != '0) && (cnt_plus == {1'b0, thresh_reg});
  assign bit_out    = bit_valid & shift_reg[WORD_W-1];
  assign in_bus.in_ready = ready_reg;

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (start && legal) state_next = WAIT;
        WAIT:  if (in_bus.in_valid) state_next = SHIFT;
        SHIFT: begin
          if (hit_thresh) state_next = DONE;
          else if (k_reg == KW'(WORD_W - 1)) state_next = WAIT;
        end
        DONE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      ready_reg  <= 1'b0;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      shift_reg  <= '0;
      k_reg      <= '0;
      pat_reg    <= '0;
      len_reg    <= '0;
      thresh_reg <= '0;
      match_cnt  <= '0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      ready_reg <= (state_next == WAIT);
      bit_valid <= (state_next == SHIFT);
      done      <= (state_next == DONE);
      cfg_err   <= (state_reg == IDLE) && start && !abort && !legal;
      if (accept) begin
        pat_reg    <= cfg_pattern;
        len_reg    <= cfg_len;
        thresh_reg <= cfg_thresh;
        match_cnt  <= '0;
      end
      if (!abort) begin
        case (state_reg)
          WAIT: if (in_bus.in_valid) begin
            shift_reg <= in_bus.in_data;
            k_reg     <= '0;
          end
          SHIFT: begin
            shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
            k_reg     <= k_reg + KW'(1);
            if (match && (match_cnt != '1)) match_cnt <= cnt_plus[CNT_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  pattern_matcher #(.PAT_MAX(PAT_MAX)) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_out),
    .bit_valid (bit_valid),
    .clr       (accept),
    .pattern   (pat_reg),
    .len       (len_reg),
    .match     (match)
  );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: table vectors, corner sequences, per-bit scoreboard.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       bit_out, bit_valid, match, busy, done, cfg_err;
  logic [7:0] match_cnt;

  pattern_scan_ctrl_if #(.WORD_W(8)) bus ();

  pattern_scan_ctrl #(.WORD_W(8), .PAT_MAX(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .in_bus      (bus),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic m;
  } sb_t;

  typedef struct {
    logic [3:0] pat;
    logic [2:0] len;
    logic [7:0] thresh;
    logic [7:0] w0;
    logic [7:0] w1;
    int         nw;
    logic [7:0] cnt;
    int         ndone;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cfg_err_cnt = 0;
  logic prev_hit = 1'b0;

  // Reference model state
  int exp_hist, exp_seen, exp_cnt, cur_pat, cur_len, cur_thr;
  bit exp_stop;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (!exp_stop) begin
        int  msk;
        sb_t e;
        msk = (1 << cur_len) - 1;
        exp_hist = (exp_hist << 1) | int'(w[i]);
        e.b = w[i];
        e.m = (exp_seen >= cur_len - 1) && ((exp_hist & msk) == (cur_pat & msk));
        if (exp_seen < 4) exp_seen++;
        sb.push_back(e);
        if (e.m) begin
          if (cur_thr != 0 && exp_cnt + 1 == cur_thr) exp_stop = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
    end
  endtask

  task automatic do_start(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t);
    @(posedge clk); #1;
    cfg_pattern = p; cfg_len = l; cfg_thresh = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (l >= 3'd1 && l <= 3'd4) begin
      exp_hist = 0; exp_seen = 0; exp_cnt = 0; exp_stop = 1'b0;
      cur_pat = int'(p); cur_len = int'(l); cur_thr = int'(t);
    end
  endtask

  // Returns cycles from handshake until in_ready is back (or busy drops).
  task automatic send_word(input logic [7:0] w, output int lat);
    int t;
    model_word(w);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = w;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin
        check("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        lat = -1;
        return;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.in_ready && busy && lat < 40);
  endtask

  task automatic do_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        done_cnt++;
        check("done_after_match", 32'(prev_hit), 32'd1);
      end
      if (cfg_err) cfg_err_cnt++;
      if (bit_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_bit: got bit %0b match %0b with no expected bit", bit_out, match);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("bit_match", {30'd0, bit_out, match}, {30'd0, e.b, e.m});
        end
      end
      prev_hit = bit_valid && match;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, e0, busy_seen;
    vecs[0] = '{4'b0101, 3'd3, 8'd0, 8'hAA, 8'h00, 1, 8'd3, 0};
    vecs[1] = '{4'b0101, 3'd3, 8'd2, 8'hAA, 8'h00, 1, 8'd2, 1};
    vecs[2] = '{4'b0101, 3'd3, 8'd0, 8'h01, 8'h40, 2, 8'd1, 0};
    vecs[3] = '{4'b0001, 3'd1, 8'd0, 8'hFF, 8'h00, 1, 8'd8, 0};
    vecs[4] = '{4'b0110, 3'd4, 8'd0, 8'h66, 8'h00, 1, 8'd2, 0};
    vecs[5] = '{4'b0011, 3'd2, 8'd3, 8'hFF, 8'h00, 1, 8'd3, 1};
    vecs[6] = '{4'b0000, 3'd1, 8'd0, 8'h0F, 8'h00, 1, 8'd4, 0};

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #3;
    check("reset_state", {23'd0, busy, bus.in_ready, bit_valid, match_cnt},  32'd0);
    check("reset_pulses", {29'd0, done, cfg_err, match}, 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      do_start(vecs[v].pat, vecs[v].len, vecs[v].thresh);
      send_word(vecs[v].w0, lat);
      if (vecs[v].thresh == 8'd0) check("latency", 32'(lat), 32'd9);
      if (vecs[v].nw > 1) begin
        send_word(vecs[v].w1, lat);
        check("latency_w1", 32'(lat), 32'd9);
      end
      if (vecs[v].ndone == 0) do_abort();
      @(negedge clk);
      check("match_cnt", 32'(match_cnt), 32'(vecs[v].cnt));
      check("idle_busy", 32'(busy), 32'd0);
      check("done_pulses", 32'(done_cnt - d0), 32'(vecs[v].ndone));
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("vec %0d: pat %b len %0d thr %0d -> match_cnt %0d", v, vecs[v].pat, vecs[v].len, vecs[v].thresh, match_cnt);
    end

    // Illegal lengths: one cfg_err pulse, no activity
    for (int i = 0; i < 2; i++) begin
      logic [2:0] bad;
      bad = (i == 0) ? 3'd0 : 3'd5;
      e0 = cfg_err_cnt;
      busy_seen = 0;
      do_start(4'b0101, bad, 8'd0);
      repeat (4) begin
        @(negedge clk);
        if (busy || bus.in_ready) busy_seen++;
      end
      check("cfg_err_pulse", 32'(cfg_err_cnt - e0), 32'd1);
      check("cfg_err_quiet", 32'(busy_seen), 32'd0);
      $display("cfg_len %0d: cfg_err pulses %0d", bad, cfg_err_cnt - e0);
    end

    // Asynchronous reset at k = 3
    do_start(4'b0001, 3'd1, 8'd0);
    model_word(8'hFF);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_cnt", 32'(match_cnt), 32'd3);
    check("pre_reset_valid", 32'(bit_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_reset", {22'd0, busy, bit_valid, match, bus.in_ready, match_cnt}, 32'd0);
    sb.delete();
    #10 rst = 1'b1;
    do_start(4'b0001, 3'd1, 8'd0);
    send_word(8'hFF, lat);
    check("post_reset_latency", 32'(lat), 32'd9);
    do_abort();
    @(negedge clk);
    check("post_reset_cnt", 32'(match_cnt), 32'd8);
    $display("reset mid-scan: rescan match_cnt %0d", match_cnt);

    // Saturation with ignored start pulses and config changes
    do_start(4'b0001, 3'd1, 8'd0);
    for (int w = 0; w < 300; w++) begin
      send_word(8'hFF, lat);
      if (w % 50 == 25) begin
        cfg_pattern = 4'b0000; cfg_len = 3'd2; cfg_thresh = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("sat_busy", 32'(busy), 32'd1);
    check("sat_cnt", 32'(match_cnt), 32'd255);
    do_abort();
    @(negedge clk);
    check("sat_cnt_kept", 32'(match_cnt), 32'd255);
    check("sat_sb_empty", 32'(sb.size()), 32'd0);
    $display("saturation: 300 words -> match_cnt %0d", match_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Sequencing controller for the team's serial pattern detector.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first into an internal overlapping Mealy matcher with a programmable pattern of 1..PAT_MAX bits.
- Counts matches and terminates the scan with a done pulse when a programmable match threshold is reached.
- Sits between a word-producing front end and the interrupt/status logic.

Parameters:
WORD_W, 8, width of input word (bits serialized per accepted word)
PAT_MAX, 4, maximum pattern length in bits
CNT_W, 8, width of match counter and threshold

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle request to begin a scan; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state next edge
cfg_pattern  input  PAT_MAX  pattern; bit [cfg_len-1] is the first expected bit, bit 0 the last
cfg_len  input  3  pattern length; legal 1..PAT_MAX
cfg_thresh  input  CNT_W  match count that ends the scan; 0 = free-running
in_valid  input  1  word available
in_data  input  WORD_W  word to scan
in_ready  output  1  block can accept a word this cycle
bit_out  output  1  bit currently presented to the matcher
bit_valid  output  1  bit_out is valid this cycle
match  output  1  combinational Mealy match pulse, qualified by bit_valid
match_cnt  output  CNT_W  matches since start, saturating
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on threshold reached
cfg_err  output  1  one-cycle pulse when start is seen with illegal cfg_len

Behaviour:
- Reset values: state IDLE, all registered outputs 0, history 0, seen-count 0, match_cnt 0.
- A handshake occurs when in_valid && in_ready. in_ready is high only in WAIT.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE, start with 1 <= cfg_len <= PAT_MAX: latch cfg_pattern, cfg_len and cfg_thresh; clear history, seen-count and match_cnt; go to WAIT.
- IDLE, start with illegal cfg_len: pulse cfg_err; stay in IDLE.
- WAIT: on handshake, capture in_data into the shift register, set bit index k = 0, go to SHIFT. The history is NOT cleared, so patterns may span word boundaries.
- SHIFT cycle k: bit_out = word[WORD_W-1-k] and bit_valid = 1.
- match = bit_valid && seen >= cfg_len-1 && ({hist, bit_out} low cfg_len bits == latched pattern low cfg_len bits). Matches may overlap.
- On each SHIFT edge: hist <= {hist, bit_out}; seen increments, saturating at PAT_MAX.
- If match, match_cnt increments, saturating at all-ones.
- If match && thresh != 0 && match_cnt+1 == thresh: go to DONE. Any remaining bits of the word are discarded.
- Otherwise, after k = WORD_W-1, return to WAIT.
- Latency: word accepted at edge N; first bit presented in cycle N+1; last bit presented in cycle N+WORD_W; in_ready high again in cycle N+WORD_W+1.
- DONE: done = 1 for exactly one cycle, then IDLE. match_cnt holds its value until the next legal start.
- abort has priority over every transition: next state IDLE, no done pulse, match_cnt retained.
- start while busy: ignored.
- Asynchronous reset mid-SHIFT: immediately returns to IDLE with all outputs 0. The word in progress is lost.
- Latched config is unaffected by cfg_* changes during a scan.

Decomposition:
- Shared package pattern_scan_pkg: state encoding constants IDLE = 0, WAIT = 1, SHIFT = 2, DONE = 3; default PAT_MAX; cfg_len legality check function.
- One sub-module, pattern_matcher: history register, seen counter, compare, and the match output, with ports bit_in, bit_valid, clr, pattern, len, match.
- The controller FSM, shift register and counter stay in pattern_scan_ctrl.

Test Plan:
- Pattern 101, len 3, thresh 0, word 0xAA -> match in SHIFT cycles k = 2, 4, 6; match_cnt = 3; in_ready returns 9 cycles after the handshake.
- Same configuration with thresh 2, word 0xAA -> done pulses the cycle after k = 4; bits k = 5..7 are never presented; state returns to IDLE; match_cnt = 2.
- Pattern 101, len 3, words 0x01 then 0x40 -> exactly one match, at k = 1 of the second word (cross-word history).
- cfg_len 0 and 5 with start -> cfg_err pulses once; busy stays 0; in_ready stays 0.
- Reset asserted (rst = 0) at k = 3 of 0xFF with pattern 1, len 1 -> busy, bit_valid, match and match_cnt drop to 0 asynchronously; the next start scans cleanly.
- Pattern 1, len 1, 300 words of 0xFF, thresh 0 -> match_cnt saturates at 255; start pulses while busy have no effect.
